// File: rtl/riscv_pkg.sv
// Shared instruction-path types for the fetch -> dispatch boundary.
package riscv_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for the instruction queue: one synchronous write port and one
// asynchronous read port. Contents are never cleared, only overwritten.
module instr_queue_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(iq_entry_t),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular FWFT queue between fetch and dispatch with single-cycle flush.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module instr_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = riscv_pkg::INSTR_W,
  parameter int PC_W   = riscv_pkg::PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_instr,
  input  logic [PC_W-1:0]          wr_pc,
  output logic                     full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [PC_W-1:0]          rd_pc,
  output logic                     empty,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + DATA_W;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push;
  logic          pop;
  logic          mem_we;
  logic [EW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // full/empty come from registered pointers only, so a pop never frees a slot
  // for a push in the same cycle.
  assign push   = wr_en && !full;
  assign pop    = rd_en && !empty;
  assign mem_we = push && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  instr_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({wr_pc, wr_instr}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  assign rd_instr = empty ? '0 : head[DATA_W-1:0];
  assign rd_pc    = empty ? '0 : head[EW-1:DATA_W];

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a queue-based reference model checked every
// cycle, plus hand-computed literal checkpoints along the test sequence.
module tb_instr_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_instr = '0;
  logic [31:0] wr_pc = '0;
  logic        full;
  logic        rd_en = 1'b0;
  logic [31:0] rd_instr;
  logic [31:0] rd_pc;
  logic        empty;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int nchecks = 0;
  int nfail   = 0;
  bit started = 1'b0;

  logic [63:0] model_q[$];

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_instr (wr_instr),
    .wr_pc    (wr_pc),
    .full     (full),
    .rd_en    (rd_en),
    .rd_instr (rd_instr),
    .rd_pc    (rd_pc),
    .empty    (empty),
    .flush    (flush),
    .count    (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model outputs are derived from queue occupancy, not from pointers.
  always @(negedge clk) begin
    if (started) begin
      chk("m_empty", {31'b0, empty}, {31'b0, model_q.size() == 0});
      chk("m_full",  {31'b0, full},  {31'b0, model_q.size() == DEPTH});
      chk("m_count", {29'b0, count}, model_q.size());
      chk("m_instr", rd_instr, (model_q.size() != 0) ? model_q[0][31:0]  : 32'h0);
      chk("m_pc",    rd_pc,    (model_q.size() != 0) ? model_q[0][63:32] : 32'h0);
    end
  end

  // One clock cycle: drive inputs, let the edge happen, then advance the model
  // using the occupancy seen before the edge.
  task automatic step(input bit w, input logic [31:0] ins, input logic [31:0] pc,
                      input bit r, input bit fl, input bit rs);
    bit do_push;
    bit do_pop;
    wr_en = w; wr_instr = ins; wr_pc = pc; rd_en = r; flush = fl; rst = rs;
    do_push = w && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    @(posedge clk);
    if (rs || fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, ins});
    end
    started = 1'b1;
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    step(1'b1, ins, pc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset for two cycles
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full",  {31'b0, full},  32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_instr", rd_instr, 32'h0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 4; i++) push(32'hA0 + i, 32'h4 * i);
    chk("fill_full",  {31'b0, full},  32'd1);
    chk("fill_count", {29'b0, count}, 32'd4);
    push(32'hB0, 32'h10);
    chk("ovf_count", {29'b0, count}, 32'd4);
    chk("ovf_head",  rd_instr, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", rd_instr, 32'hA0 + i);
      chk("drain_pc",    rd_pc,    32'h4 * i);
      pop();
    end
    chk("drain_empty", {31'b0, empty}, 32'd1);

    // Wrap-around across the index boundary
    for (int i = 0; i < 3; i++) push(32'h90 + i, 32'h100 + 4 * i);
    for (int i = 0; i < 3; i++) pop();
    for (int i = 0; i < 4; i++) push(32'hC0 + i, 32'h200 + 4 * i);
    chk("wrap_full", {31'b0, full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_instr", rd_instr, 32'hC0 + i);
      pop();
    end
    chk("wrap_empty", {31'b0, empty}, 32'd1);

    // Simultaneous push/pop at count 2
    push(32'hE0, 32'h300);
    push(32'hE1, 32'h304);
    for (int i = 0; i < 5; i++) begin
      chk("sim_head", rd_instr, 32'hE0 + i);
      step(1'b1, 32'hE2 + i, 32'h308 + 4 * i, 1'b1, 1'b0, 1'b0);
      chk("sim_count", {29'b0, count}, 32'd2);
    end
    chk("sim_head_end", rd_instr, 32'hE5);

    // Push+pop while full: pop accepted, push dropped
    push(32'hE7, 32'h400);
    push(32'hE8, 32'h404);
    chk("pre_full", {31'b0, full}, 32'd1);
    step(1'b1, 32'hEF, 32'h4FC, 1'b1, 1'b0, 1'b0);
    chk("full_pp_count", {29'b0, count}, 32'd3);
    chk("full_pp_head",  rd_instr, 32'hE6);

    // Flush with concurrent push and pop
    step(1'b1, 32'hEE, 32'h500, 1'b1, 1'b1, 1'b0);
    chk("flush_empty", {31'b0, empty}, 32'd1);
    chk("flush_count", {29'b0, count}, 32'd0);
    push(32'hD0, 32'h600);
    chk("post_flush_instr", rd_instr, 32'hD0);
    chk("post_flush_pc",    rd_pc,    32'h600);

    // Reset mid-stream, then pop while empty
    push(32'hD1, 32'h604);
    chk("pre_rst_count", {29'b0, count}, 32'd2);
    step(1'b1, 32'hD2, 32'h608, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_full",  {31'b0, full},  32'd0);
    chk("mid_rst_count", {29'b0, count}, 32'd0);
    chk("mid_rst_instr", rd_instr, 32'h0);
    chk("mid_rst_pc",    rd_pc,    32'h0);
    pop();
    chk("ud_count", {29'b0, count}, 32'd0);
    chk("ud_empty", {31'b0, empty}, 32'd1);
    push(32'hF0, 32'h700);
    chk("ud_push_instr", rd_instr, 32'hF0);
    chk("ud_push_count", {29'b0, count}, 32'd1);
    pop();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Circular FIFO between instruction fetch (writer) and dispatch (reader) in `risc_v_superscalar`. Fetch pushes {PC, instruction} pairs each cycle the queue has room. Dispatch pops from the head with first-word-fall-through visibility. A branch-mispredict flush empties the queue in one cycle so dispatch never sees wrong-path instructions.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `DATA_W`, 32: instruction word width.
- `PC_W`, 32: program-counter width.

Ports:
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: fetch requests a push.
- `wr_instr`  in  DATA_W: instruction to push.
- `wr_pc`  in  PC_W: PC of pushed instruction.
- `full`  out  1: no free entry; push ignored.
- `rd_en`  in  1: dispatch pops the head entry.
- `rd_instr`  out  DATA_W: head instruction (FWFT).
- `rd_pc`  out  PC_W: head PC.
- `empty`  out  1: no valid entry.
- `flush`  in  1: discard all entries (mispredict/exception).
- `count`  out  $clog2(DEPTH)+1: occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {pc, instr}.
- Pointers: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = index bits equal and wrap bits differ.
  - `count` = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push accepted iff `wr_en && !full`. The entry is written at `wr_ptr` and `wr_ptr` increments, wrapping naturally.
- Pop accepted iff `rd_en && !empty`. `rd_ptr` increments.
- Push while full and pop while empty are ignored silently: no pointer change, no error flag.
- Simultaneous accepted push and pop: both take effect and `count` is unchanged.
- Push-while-full is not accepted even if a pop occurs in the same cycle. `full` is evaluated before that cycle's pop, so there is no bypass.
- Priority: `rst` > `flush` > push/pop.
  - `flush`: both pointers := 0 on the next edge. Any push or pop in the same cycle is discarded.
- `rd_instr`/`rd_pc` are combinational from the entry at `rd_ptr` when `!empty`, and 0 when `empty`.
- Storage contents are not cleared by reset or flush. Only the pointers are.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `rd_instr`=0, `rd_pc`=0. Pointers are 0.
- Write-to-read latency is 1 cycle. A push at edge N makes the entry visible on `rd_*`, with `empty` low, after edge N.
- Pop: the next entry appears on `rd_*` after the edge that accepts the pop.
- `full`, `empty` and `count` are combinational from registered pointers and are glitch-free relative to `clk`.
- Flush asserted in cycle N gives `empty`=1 and `count`=0 after edge N, regardless of `wr_en`/`rd_en`.
- Reset asserted mid-operation behaves identically to flush, and also takes priority over flush.
- No combinational path from `wr_en`/`rd_en` to `full`/`empty`.

## Structure
- `riscv_pkg`:
  - `INSTR_W` and `PC_W` constants.
  - `iq_entry_t` packed struct {pc, instr}, shared with fetch and dispatch.
- Sub-module: `instr_queue_mem`, a DEPTH×$bits(iq_entry_t) register array with one synchronous write port and one asynchronous read port. Pointer, flag and flush logic stay in `instr_queue`.

## Test plan
- Reset with `rst`=1 for 2 cycles → `empty`=1, `full`=0, `count`=0, `rd_instr`=0.
- Push PCs 0x00, 0x04, 0x08, 0x0C with instr 0xA0..0xA3 → `full`=1 and `count`=4. A fifth push of 0xB0 is ignored. Four pops return 0xA0..0xA3 in order, then `empty`=1.
- Wrap-around:
  - Push 3, pop 3, then push 4 (0xC0..0xC3).
  - → `full`=1, and the reads return 0xC0..0xC3 in order across the index wrap.
- Simultaneous:
  - With `count`=2, push and pop together for 5 cycles → `count` stays 2 and the output order is preserved.
  - With `full`=1, push and pop together → the pop is accepted, the push is dropped, and `count`=3.
- Flush: with `count`=3, assert `flush` together with `wr_en` and `rd_en` → `empty`=1 and `count`=0 next cycle. A following push of 0xD0 appears on `rd_instr` one cycle later.
- Reset mid-stream: with `count`=2, assert `rst` → next cycle all outputs are at reset values. A pop while `empty` leaves the pointers unchanged.
